// File: rtl/servo_ramp_ctrl.sv
// Servo duty sequencer: ramps the PWM duty toward a commanded target
// one bounded step per frame, holds for a few frames, then signals done.
module servo_ramp_ctrl #(
  parameter int unsigned FRAME_COUNT = 50000,
  parameter int unsigned STEP        = 4,
  parameter int unsigned HOLD_FRAMES = 2,
  parameter int unsigned DUTY_RESET  = 128,
  parameter int unsigned POS_MIN     = 0,
  parameter int unsigned POS_MAX     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_pos,
  input  logic       stop,
  output logic [7:0] duty,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] LAST   = 16'(FRAME_COUNT - 1);
  localparam logic [7:0]  STEP_V = 8'(STEP);
  localparam logic [7:0]  HOLD_V = 8'(HOLD_FRAMES);
  localparam logic [7:0]  RST_V  = 8'(DUTY_RESET);
  localparam logic [7:0]  MIN_V  = 8'(POS_MIN);
  localparam logic [7:0]  MAX_V  = 8'(POS_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_SETTLE,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  hold_q, hold_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic [7:0]  pos_clamped;
  logic [8:0]  below_lo;
  logic [8:0]  above_hi;
  logic [8:0]  diff;
  logic [8:0]  mag;
  logic        diff_neg;
  logic        near;

  // Frame counter and registered tick on the last clock of each frame.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
    tick_d = (cnt_d == LAST);
  end

  // Clamp incoming target; borrow bits of 9-bit subtractions give the compares.
  always_comb begin
    below_lo    = {1'b0, cmd_pos} - {1'b0, MIN_V};
    above_hi    = {1'b0, MAX_V} - {1'b0, cmd_pos};
    pos_clamped = cmd_pos;
    if (below_lo[8]) begin
      pos_clamped = MIN_V;
    end else if (above_hi[8]) begin
      pos_clamped = MAX_V;
    end
  end

  // Signed distance to target; duty never crosses 0 or 255 because a
  // full step is only taken when the remaining distance exceeds it.
  always_comb begin
    diff     = {1'b0, target_q} - {1'b0, duty_q};
    diff_neg = diff[8];
    mag      = diff_neg ? (9'd0 - diff) : diff;
    near     = (mag <= {1'b0, STEP_V});
  end

  assign accept = cmd_valid && ready_q;

  // Next-state, duty and hold-counter logic.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    hold_d   = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          target_d = pos_clamped;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick_q) begin
          if (near) begin
            duty_d  = target_q;
            hold_d  = HOLD_V;
            state_d = ST_SETTLE;
          end else if (diff_neg) begin
            duty_d = duty_q - STEP_V;
          end else begin
            duty_d = duty_q + STEP_V;
          end
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick_q) begin
          if (hold_q == 8'd1) begin
            state_d = ST_DONE;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered status outputs follow the upcoming state.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      tick_q   <= 1'b0;
      duty_q   <= RST_V;
      target_q <= RST_V;
      hold_q   <= 8'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign duty       = duty_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl: vector table of moves plus
// hand-written stop, queueing and async-reset sequences.
module tb_servo_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cv0 = 1'b0;
  logic       cv1 = 1'b0;
  logic [7:0] cmd_pos = 8'd0;
  logic       stop = 1'b0;

  logic       rdy0, tick0, busy0, done0;
  logic       rdy1, tick1, busy1, done1;
  logic [7:0] duty0, duty1;

  int         sel = 0;
  logic [7:0] m_duty;
  logic       m_rdy, m_tick, m_busy, m_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  servo_ramp_ctrl #(
    .FRAME_COUNT(100), .STEP(4), .HOLD_FRAMES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(rdy0),
    .cmd_pos(cmd_pos), .stop(stop), .duty(duty0),
    .frame_tick(tick0), .busy(busy0), .done(done0)
  );

  servo_ramp_ctrl #(
    .FRAME_COUNT(100), .STEP(4), .HOLD_FRAMES(2),
    .POS_MIN(20), .POS_MAX(230)
  ) u_clp (
    .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(rdy1),
    .cmd_pos(cmd_pos), .stop(stop), .duty(duty1),
    .frame_tick(tick1), .busy(busy1), .done(done1)
  );

  always_comb begin
    m_duty = (sel == 1) ? duty1 : duty0;
    m_rdy  = (sel == 1) ? rdy1  : rdy0;
    m_tick = (sel == 1) ? tick1 : tick0;
    m_busy = (sel == 1) ? busy1 : busy0;
    m_done = (sel == 1) ? done1 : done0;
  end

  typedef struct {
    int sel;
    int pos;
    int nt;
    int start;
    int fin;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tick && n < 300);
    if (!m_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: got no tick in %0d cycles required 100", n);
    end
  endtask

  task automatic count_to_tick(input string name, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tick && n < 300);
    check(name, n, exp);
  endtask

  task automatic issue(input int s, input int pos);
    sel     = s;
    cmd_pos = 8'(pos);
    if (s == 1) cv1 = 1'b1;
    else        cv0 = 1'b1;
    @(negedge clk);
    cv0 = 1'b0;
    cv1 = 1'b0;
    check("accept_busy", int'(m_busy), 1);
    check("accept_ready", int'(m_rdy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int dir;
    int exp;
    issue(v.sel, v.pos);
    dir = (v.fin >= v.start) ? 1 : -1;
    for (int k = 1; k <= v.nt; k++) begin
      wait_tick();
      @(negedge clk);
      exp = (k == v.nt) ? v.fin : v.start + dir * 4 * k;
      check("ramp_duty", int'(m_duty), exp);
    end
    wait_tick();
    @(negedge clk);
    check("settle_done", int'(m_done), 0);
    check("settle_busy", int'(m_busy), 1);
    wait_tick();
    @(negedge clk);
    check("done_pulse", int'(m_done), 1);
    check("done_duty", int'(m_duty), v.fin);
    @(negedge clk);
    check("done_clear", int'(m_done), 0);
    check("idle_busy", int'(m_busy), 0);
    check("idle_ready", int'(m_rdy), 1);
  endtask

  initial begin
    bit seen_done;

    vt[0] = '{0, 140,  3, 128, 140};
    vt[1] = '{0, 128,  3, 140, 128};
    vt[2] = '{0, 128,  1, 128, 128};
    vt[3] = '{0, 121,  2, 128, 121};
    vt[4] = '{0, 121,  1, 121, 121};
    vt[5] = '{0, 125,  1, 121, 125};
    vt[6] = '{0, 255, 33, 125, 255};
    vt[7] = '{0,   0, 64, 255,   0};
    vt[8] = '{1, 250, 26, 128, 230};
    vt[9] = '{1,   5, 53, 230,  20};

    // Reset values and tick cadence.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    #1;
    check("rst_duty", int'(duty0), 128);
    check("rst_busy", int'(busy0), 0);
    check("rst_ready", int'(rdy0), 1);
    check("rst_done", int'(done0), 0);
    check("rst_tick", int'(tick0), 0);
    check("rst_duty_clp", int'(duty1), 128);
    count_to_tick("first_tick", 99);
    count_to_tick("tick_period", 100);

    for (int i = 0; i < 10; i++) begin
      run_vec(vt[i]);
    end

    // Stop on the second ramp tick; a command held while busy is dropped.
    sel = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 140);
    cv0 = 1'b1;
    cmd_pos = 8'd0;
    repeat (20) begin
      @(negedge clk);
      check("held_ready", int'(rdy0), 0);
    end
    cv0 = 1'b0;
    wait_tick();
    @(negedge clk);
    check("stop_first", int'(duty0), 132);
    wait_tick();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_duty", int'(duty0), 132);
    check("stop_busy", int'(busy0), 0);
    check("stop_ready", int'(rdy0), 1);
    check("stop_done", int'(done0), 0);
    seen_done = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (done0) seen_done = 1'b1;
    end
    check("stop_no_done", int'(seen_done), 0);
    check("stop_hold_duty", int'(duty0), 132);
    check("stop_idle", int'(busy0), 0);

    // Stop while idle is ignored; next move still completes.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("idle_stop_ready", int'(rdy0), 1);
    run_vec('{0, 136, 1, 132, 136});

    // Asynchronous reset between clock edges mid-ramp.
    issue(0, 160);
    wait_tick();
    @(negedge clk);
    check("pre_rst_duty", int'(duty0), 140);
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_duty", int'(duty0), 128);
    check("async_busy", int'(busy0), 0);
    check("async_ready", int'(rdy0), 1);
    check("async_done", int'(done0), 0);
    @(negedge clk);
    rst = 1'b0;
    count_to_tick("post_rst_tick", 99);
    check("post_rst_duty", int'(duty0), 128);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
